// File: rtl/cache_line_mover.sv
// Line transfer engine: optionally writes a victim line back to memory word by word,
// then refills the line from memory and commits tag, clean state and LRU tick.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// WB    | writing victim words {old_tag, set, w} to memory
// FILL  | reading words {new_tag, set, w} from memory into the line
// DONE  | one-cycle completion pulse
module cache_line_mover #(
  parameter int TAG_WIDTH  = 20,
  parameter int SET_WIDTH  = 8,
  parameter int LINE_WIDTH = 4,
  parameter int KEY_WIDTH  = 2,
  parameter int N          = 2**(LINE_WIDTH-2)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [KEY_WIDTH-1:0]  req_key,
  input  logic [SET_WIDTH-1:0]  req_set,
  input  logic                  req_dirty,
  input  logic [TAG_WIDTH-1:0]  req_old_tag,
  input  logic [TAG_WIDTH-1:0]  req_new_tag,
  input  logic [31:0]           req_tick,
  output logic                  line_en,
  output logic                  line_by_tag,
  output logic [KEY_WIDTH-1:0]  line_key,
  output logic [LINE_WIDTH-1:0] line_index,
  output logic [2:0]            line_ctrl,
  output logic [31:0]           line_data,
  output logic [31:0]           line_set_tick,
  output logic [TAG_WIDTH-1:0]  line_set_tag,
  input  logic                  line_hit,
  input  logic [31:0]           line_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam int WW = LINE_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WW-1:0]          r_w;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [SET_WIDTH-1:0]   r_set;
  logic [TAG_WIDTH-1:0]   r_old_tag;
  logic [TAG_WIDTH-1:0]   r_new_tag;
  logic [31:0]            r_tick;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_unused_hit;

  // line_hit is a controller contract; the mover never consumes it.
  assign w_unused_hit = line_hit;

  assign w_last   = (r_w == WW'(N-1));
  assign w_accept = (r_state == IDLE) && req_valid;

  assign line_by_tag   = 1'b0;
  assign line_key      = r_key;
  assign line_index    = {r_w, 2'b00};
  assign line_data     = mem_rdata;
  assign line_set_tick = r_tick;
  assign line_set_tag  = r_new_tag;
  assign mem_wdata     = line_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {r_new_tag, r_set, r_w, 2'b00};
    line_en     = 1'b0;
    line_ctrl   = 3'b000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_state_nxt = req_dirty ? WB : FILL;
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {r_old_tag, r_set, r_w, 2'b00};
        if (mem_ack && w_last) w_state_nxt = FILL;
      end
      FILL: begin
        mem_req = 1'b1;
        line_en = mem_ack;
        // The last word also loads tag, valid, clean and tick in one write.
        line_ctrl = w_last ? 3'b111 : 3'b001;
        if (mem_ack && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w       <= '0;
      r_key     <= '0;
      r_set     <= '0;
      r_old_tag <= '0;
      r_new_tag <= '0;
      r_tick    <= '0;
    end else if (w_accept) begin
      r_w       <= '0;
      r_key     <= req_key;
      r_set     <= req_set;
      r_old_tag <= req_old_tag;
      r_new_tag <= req_new_tag;
      r_tick    <= req_tick;
    end else if (mem_req && mem_ack) begin
      r_w <= r_w + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_line_mover.sv
// Self-checking bench for cache_line_mover: emulates the cache line and memory,
// predicts the full memory/line transaction sequence per request.
module tb_cache_line_mover;
  localparam int TW = 20, SW = 8, LW = 4, KW = 2, N = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic req_valid, req_ready, req_dirty;
  logic [KW-1:0] req_key;
  logic [SW-1:0] req_set;
  logic [TW-1:0] req_old_tag, req_new_tag;
  logic [31:0] req_tick;
  logic line_en, line_by_tag, line_hit;
  logic [KW-1:0] line_key;
  logic [LW-1:0] line_index;
  logic [2:0] line_ctrl;
  logic [31:0] line_data, line_set_tick, line_out;
  logic [TW-1:0] line_set_tag;
  logic mem_req, mem_we, mem_ack, busy, done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Line model
  logic [31:0] lw [N];
  logic [TW-1:0] l_tag;
  logic [31:0] l_tick;
  logic l_dirty, l_valid;

  int n_cmp = 0;
  int n_err = 0;

  assign line_out = lw[line_index[LW-1:2]];
  assign line_hit = 1'b1;

  always #5 clk = ~clk;

  cache_line_mover #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW), .KEY_WIDTH(KW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_set(req_set),
    .req_dirty(req_dirty), .req_old_tag(req_old_tag), .req_new_tag(req_new_tag),
    .req_tick(req_tick),
    .line_en(line_en), .line_by_tag(line_by_tag), .line_key(line_key),
    .line_index(line_index), .line_ctrl(line_ctrl), .line_data(line_data),
    .line_set_tick(line_set_tick), .line_set_tag(line_set_tag),
    .line_hit(line_hit), .line_out(line_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always @(negedge clk)
    if (reset_n && busy) assert (line_hit) else $error("line_hit low while busy");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [TW-1:0] t, input logic [SW-1:0] s, input int i);
    return (32'(t) << (SW + LW)) | (32'(s) << LW) | 32'(i * 4);
  endfunction

  task automatic run_req(input logic [KW-1:0] key, input logic [SW-1:0] set, input bit dirty,
                         input logic [TW-1:0] otag, input logic [TW-1:0] ntag,
                         input logic [31:0] tick, input int stall_max, input bit noise,
                         input int abort_at);
    logic [31:0] e_addr [2*N];
    bit          e_we   [2*N];
    logic [31:0] e_wd   [2*N];
    logic [31:0] refill [N];
    logic [31:0] p_addr, p_wd;
    logic        p_we;
    bit          p_stall, fin;
    int          ne, nwb, pe, nwr, c, stall;

    ne = 0;
    if (dirty) for (int i = 0; i < N; i++) begin
      e_we[ne] = 1'b1; e_addr[ne] = mk(otag, set, i); e_wd[ne] = lw[i]; ne++;
    end
    nwb = ne;
    for (int i = 0; i < N; i++) begin
      e_we[ne] = 1'b0; e_addr[ne] = mk(ntag, set, i); e_wd[ne] = '0; ne++;
    end
    for (int i = 0; i < N; i++) refill[i] = '0;

    @(negedge clk);
    req_valid = 1'b1; req_key = key; req_set = set; req_dirty = dirty;
    req_old_tag = otag; req_new_tag = ntag; req_tick = tick; mem_ack = 1'b0;
    #1 chk("accept_ready", req_ready, 1);
    chk("line_by_tag", line_by_tag, 0);

    pe = 0; nwr = 0; c = 0; p_stall = 0; fin = 0;
    p_addr = '0; p_wd = '0; p_we = 1'b0;
    stall = $urandom_range(0, stall_max);
    while (!fin && c < 200) begin
      @(negedge clk);
      c++;
      if (noise) begin
        req_valid = 1'b1; req_key = KW'($urandom); req_set = SW'($urandom);
        req_dirty = 1'($urandom); req_old_tag = TW'($urandom); req_new_tag = TW'($urandom);
        req_tick = $urandom;
      end else req_valid = 1'b0;
      if (stall > 0) begin mem_ack = 1'b0; stall--; end
      else mem_ack = 1'b1;
      mem_rdata = $urandom;
      #1;
      if (abort_at >= 0 && pe == abort_at && mem_req && mem_we) begin
        reset_n = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0); chk("rst_line_en", line_en, 0);
        chk("rst_busy", busy, 0); chk("rst_line_ctrl", line_ctrl, 0);
        chk("rst_done", done, 0);
        repeat (3) begin
          @(negedge clk); mem_ack = 1'b1;
          #1 chk("rst_hold_mem_req", mem_req, 0); chk("rst_hold_line_en", line_en, 0);
        end
        @(negedge clk); reset_n = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
        #1 chk("rst_rel_ready", req_ready, 1); chk("rst_rel_busy", busy, 0);
        return;
      end
      chk("busy", busy, 1);
      chk("req_ready_busy", req_ready, 0);
      if (p_stall) begin
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_we", mem_we, p_we);
        chk("stall_wdata", mem_wdata, p_wd);
      end
      p_stall = mem_req && !mem_ack;
      p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
      if (mem_req && mem_ack) begin
        if (pe < ne) begin
          chk("mem_we", mem_we, e_we[pe]);
          chk("mem_addr", mem_addr, e_addr[pe]);
          if (e_we[pe]) chk("mem_wdata", mem_wdata, e_wd[pe]);
          else refill[pe - nwb] = mem_rdata;
        end else chk("extra_mem_txn", pe, ne - 1);
        pe++;
        stall = $urandom_range(0, stall_max);
      end
      if (line_en) begin
        chk("line_key", line_key, key);
        chk("line_ctrl", line_ctrl, (nwr == N-1) ? 3'd7 : 3'd1);
        lw[line_index[LW-1:2]] = line_data;
        if (line_ctrl[1]) begin l_tag = line_set_tag; l_dirty = 1'b0; l_valid = 1'b1; end
        if (line_ctrl[2]) l_tick = line_set_tick;
        nwr++;
      end
      if (done) begin
        fin = 1;
        if (stall_max == 0) chk("latency", c, dirty ? 2*N+1 : N+1);
        chk("txn_count", pe, ne);
      end
    end
    if (!fin) chk("timeout_done", 0, 1);
    @(negedge clk); req_valid = 1'b0; mem_ack = 1'b0;
    #1 chk("done_width", done, 0);
    chk("idle_ready", req_ready, 1);
    chk("line_writes", nwr, N);
    for (int i = 0; i < N; i++) chk("line_word", lw[i], refill[i]);
    chk("line_tag", l_tag, ntag);
    chk("line_tick", l_tick, tick);
    chk("line_dirty", l_dirty, 0);
    chk("line_valid", l_valid, 1);
  endtask

  task automatic preload(input bit dirty, input logic [TW-1:0] otag);
    for (int i = 0; i < N; i++) lw[i] = $urandom;
    l_tag = otag; l_dirty = dirty; l_valid = 1'b1; l_tick = '0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_key = '0; req_set = '0; req_dirty = 1'b0;
    req_old_tag = '0; req_new_tag = '0; req_tick = '0; mem_ack = 1'b0; mem_rdata = '0;
    preload(0, '0);
    #1;
    chk("reset_ready", req_ready, 1); chk("reset_busy", busy, 0);
    chk("reset_done", done, 0); chk("reset_mem_req", mem_req, 0);
    chk("reset_line_en", line_en, 0); chk("reset_line_ctrl", line_ctrl, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Stray acks in IDLE must not move the FSM.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ack = (i % 2 == 0); mem_rdata = $urandom;
      #1 chk("stray_busy", busy, 0); chk("stray_line_en", line_en, 0);
      chk("stray_mem_req", mem_req, 0);
    end
    mem_ack = 1'b0;

    preload(0, 20'h7);
    run_req(2'd1, 8'd5, 0, 20'h7, 20'h12, 32'hCAFE_0001, 0, 0, -1);

    preload(1, 20'h3);
    for (int i = 0; i < N; i++) lw[i] = 32'hA0 + 32'(i);
    run_req(2'd2, 8'd9, 1, 20'h3, 20'h44, 32'h0000_1234, 0, 0, -1);

    for (int r = 0; r < 10; r++) begin
      bit d;
      logic [TW-1:0] ot;
      d = 1'($urandom);
      ot = TW'($urandom);
      preload(d, ot);
      run_req(KW'($urandom), SW'($urandom), d, ot, TW'($urandom), $urandom, 3, 1'($urandom), -1);
    end

    preload(1, 20'h55);
    run_req(2'd3, 8'd17, 1, 20'h55, 20'h66, 32'h1, 0, 0, 2);

    preload(1, 20'h21);
    run_req(2'd0, 8'd33, 1, 20'h21, 20'h31, 32'h77, 1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_line_mover.md
# cache_line_mover

Line transfer engine that sits between the cache controller and main memory and drives one cache line's port bundle as the initiator. On a miss it optionally writes the victim line back word by word, then refills the line from memory. It commits the new tag, clears dirty and sets the LRU tick on the final refill word. The controller hands it a victim key and tags, then waits for `done`; the mover owns the line port only while `busy`.

## Interface
Parameters:
- `TAG_WIDTH`, default `CACHE_T`: tag width.
- `SET_WIDTH`, default `CACHE_S`: set-index width. `TAG_WIDTH + SET_WIDTH + LINE_WIDTH` must equal 32.
- `LINE_WIDTH`, default `CACHE_B`: byte-offset width. Must be ≥ 3.
- `KEY_WIDTH`, default `$clog2(CACHE_E)`: line key width within a set.
- `N`, default `2**(LINE_WIDTH-2)`: words per line. Derived; do not override.

Ports:
- `clk`  in  1  the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  transfer request.
- `req_ready`  out  1  high only in IDLE.
- `req_key`  in  KEY_WIDTH  victim line key.
- `req_set`  in  SET_WIDTH  set index.
- `req_dirty`  in  1  victim needs write-back.
- `req_old_tag`  in  TAG_WIDTH  victim tag.
- `req_new_tag`  in  TAG_WIDTH  tag to fetch.
- `req_tick`  in  32  LRU tick to commit.
- `line_en`  out  1  line write strobe.
- `line_by_tag`  out  1  constant 0; the mover always selects the line by key.
- `line_key`  out  KEY_WIDTH  latched key.
- `line_index`  out  LINE_WIDTH  `{word, 2'b00}`.
- `line_ctrl`  out  3  `{tick_en, update_en, write_en}`.
- `line_data`  out  32  refill word.
- `line_set_tick`  out  32  latched tick.
- `line_set_tag`  out  TAG_WIDTH  latched new tag.
- `line_hit`  in  1  selected line's hit.
- `line_out`  in  32  selected line's word; combinational read.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  request accepted this cycle.
- `mem_rdata`  in  32  read data, valid with `mem_ack` on reads.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
States and transitions:
- IDLE: moves to WB on accept (`req_valid && req_ready`) if `req_dirty`, otherwise to FILL.
- WB: moves to FILL after word N-1 completes.
- FILL: moves to DONE after word N-1 completes.
- DONE: moves to IDLE.

Request latching:
- On accept, latch all `req_*` fields and clear the word counter `w` (LINE_WIDTH-2 bits).
- `req_*` are ignored outside accept.

WB state:
- Drive `mem_req=1`, `mem_we=1`, `mem_addr={old_tag, set, w, 2'b00}`, `mem_wdata=line_out`, `line_index={w,2'b00}`.
- Hold `line_en=0`.
- When `mem_ack=1`: `w` increments; at `w==N-1` it wraps to 0 and the state moves to FILL.

FILL state:
- Drive `mem_req=1`, `mem_we=0`, `mem_addr={new_tag, set, w, 2'b00}`.
- `line_en=mem_ack` (combinational), `line_data=mem_rdata`.
- `line_ctrl=3'b001` for words 0..N-2.
- `line_ctrl=3'b111` for word N-1. This single write stores the word, sets valid, loads the tag, clears dirty and loads the tick.

DONE state:
- `done=1` for exactly one cycle, then IDLE.

Invariants:
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req && !mem_ack`.
- `line_by_tag=0` always.
- `line_hit=0` while busy is a controller error. The mover does not check it; it is flagged only by a bench assertion.

## Timing
- Reset (`reset_n` low, asynchronous) forces IDLE and `w=0`, with `req_ready=1`, `busy=0`, `done=0`, `mem_req=0`, `line_en=0` and `line_ctrl=0`, all immediately.
- Reset mid-transfer abandons the operation with no further memory or line traffic. The line is left partially written; the system reset clears it.
- A word completes on any rising edge where `mem_req && mem_ack`. `mem_ack` may be high in the first cycle of a request.
- Back-to-back words are allowed: the next request is driven the cycle after completion.
- `mem_ack` while `mem_req=0` is ignored.
- Minimum latency from accept edge to `done` high:
  - dirty victim: 2N+1 cycles.
  - clean victim: N+1 cycles.
- A new request is accepted no earlier than the cycle after `done`.

## Test plan
- Clean miss, LINE_WIDTH=4, `mem_ack` tied high, set=5, new_tag=0x12 → 4 reads at `{0x12,5,w,00}` for w=0..3. `line_ctrl` is 001,001,001,111. `done` is high 5 cycles after accept. Line ends valid, not dirty, tag 0x12, tick = `req_tick`.
- Dirty miss, line preloaded with 0xA0..0xA3, old_tag=0x3 → 4 writes carrying 0xA0..0xA3 at old_tag addresses, then 4 reads at new_tag addresses. `done` is high 9 cycles after accept.
- Random `mem_ack` stalls of 0–3 cycles → address, `mem_we` and `mem_wdata` are stable during each stall. The line receives exactly 4 writes; no word is skipped or repeated.
- `req_valid` asserted while busy, with different fields → ignored. `req_ready=0` while busy. The latched key and tags are unchanged through `done`.
- `reset_n` pulled low during WB word 2 → `mem_req`, `line_en` and `busy` are 0 in the same cycle. After release the mover is in IDLE, `req_ready=1`, and a fresh request runs normally.
- `mem_ack` pulses while in IDLE, and `done` timing → no state change from the stray acks, no `line_en`. `done` is exactly one cycle wide.
